// File: rtl/instr_encoder_stream_pkg.sv
`default_nettype none
// ============================================================================
// Module : instr_encoder_stream_pkg
// Brief  : Assembly mnemonics, MIPS opcode/funct values and word-format helpers.
// Rev    : 1.0  initial release
// ============================================================================
package instr_encoder_stream_pkg;

    typedef enum logic [4:0] {
        OP_ADDU    = 5'd0,
        OP_SUBU    = 5'd1,
        OP_JR      = 5'd2,
        OP_SYSCALL = 5'd3,
        OP_BEQ     = 5'd4,
        OP_BNE     = 5'd5,
        OP_J       = 5'd6,
        OP_JAL     = 5'd7,
        OP_ADDIU   = 5'd8,
        OP_SLTI    = 5'd9,
        OP_ORI     = 5'd10,
        OP_XORI    = 5'd11,
        OP_LUI     = 5'd12,
        OP_LW      = 5'd13,
        OP_SW      = 5'd14,
        OP_LI      = 5'd15,
        OP_MOVE    = 5'd16,
        OP_NOP     = 5'd17,
        OP_B       = 5'd18
    } asm_op_t;

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_SECOND = 1'b1
    } enc_state_t;

    localparam logic [5:0] C_OPC_SPECIAL = 6'h00;
    localparam logic [5:0] C_OPC_J       = 6'h02;
    localparam logic [5:0] C_OPC_JAL     = 6'h03;
    localparam logic [5:0] C_OPC_BEQ     = 6'h04;
    localparam logic [5:0] C_OPC_BNE     = 6'h05;
    localparam logic [5:0] C_OPC_ADDIU   = 6'h09;
    localparam logic [5:0] C_OPC_SLTI    = 6'h0a;
    localparam logic [5:0] C_OPC_ORI     = 6'h0d;
    localparam logic [5:0] C_OPC_XORI    = 6'h0e;
    localparam logic [5:0] C_OPC_LUI     = 6'h0f;
    localparam logic [5:0] C_OPC_LW      = 6'h23;
    localparam logic [5:0] C_OPC_SW      = 6'h2b;

    localparam logic [5:0] C_FN_JR       = 6'h08;
    localparam logic [5:0] C_FN_SYSCALL  = 6'h0c;
    localparam logic [5:0] C_FN_ADDU     = 6'h21;
    localparam logic [5:0] C_FN_SUBU     = 6'h23;

    localparam logic [31:0] C_NOP_WORD     = 32'h0000_0021;
    localparam logic [31:0] C_SYSCALL_WORD = {26'h0, C_FN_SYSCALL};

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] funct);
        return {C_OPC_SPECIAL, rs, rt, rd, 5'b0, funct};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] opc, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm16);
        return {opc, rs, rt, imm16};
    endfunction

    function automatic logic [31:0] enc_j(input logic [5:0] opc, input logic [25:0] target);
        return {opc, target};
    endfunction

endpackage
`default_nettype wire

// File: rtl/instr_encoder_stream_if.sv
`default_nettype none
// ============================================================================
// Module : instr_encoder_stream_if
// Brief  : Request and word-output handshake channels of the encoder.
// Rev    : 1.0  initial release
// ============================================================================
interface instr_encoder_stream_if;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_op;
    logic [4:0]  in_rs;
    logic [4:0]  in_rt;
    logic [4:0]  in_rd;
    logic [31:0] in_imm;
    logic [25:0] in_target;

    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_word;
    logic [31:0] out_addr;
    logic        out_last;

    // Host side: issues requests and consumes words.
    modport master (
        output in_valid, in_op, in_rs, in_rt, in_rd, in_imm, in_target, out_ready,
        input  in_ready, out_valid, out_word, out_addr, out_last
    );

    // Encoder side.
    modport slave (
        input  in_valid, in_op, in_rs, in_rt, in_rd, in_imm, in_target, out_ready,
        output in_ready, out_valid, out_word, out_addr, out_last
    );
endinterface
`default_nettype wire

// File: rtl/instr_encoder_stream_word_pack.sv
`default_nettype none
// ============================================================================
// Module : instr_word_pack
// Brief  : Combinational (op, fields, phase) -> encoded word, two-word flag, invalid flag.
// Rev    : 1.0  initial release
// ============================================================================
module instr_word_pack
    import instr_encoder_stream_pkg::*;
#(
    parameter bit LI_COMPACT = 1'b1
) (
    input  wire  [4:0]  i_op,
    input  wire  [4:0]  i_rs,
    input  wire  [4:0]  i_rt,
    input  wire  [4:0]  i_rd,
    input  wire  [31:0] i_imm,
    input  wire  [25:0] i_target,
    input  wire         i_phase,
    output logic [31:0] o_word,
    output logic        o_two_word,
    output logic        o_invalid
);

    asm_op_t     w_op;
    logic [15:0] w_imm16;
    logic        w_li_fits_ori;
    logic        w_li_fits_addiu;
    logic        w_li_single;

    assign w_op            = asm_op_t'(i_op);
    assign w_imm16         = i_imm[15:0];
    assign w_li_fits_ori   = (i_imm[31:16] == 16'h0000);
    assign w_li_fits_addiu = &i_imm[31:15];
    assign w_li_single     = LI_COMPACT && (w_li_fits_ori || w_li_fits_addiu);

    always_comb begin
        o_word     = 32'h0000_0000;
        o_two_word = 1'b0;
        o_invalid  = 1'b0;
        case (w_op)
            OP_ADDU:    o_word = enc_r(i_rs, i_rt, i_rd, C_FN_ADDU);
            OP_SUBU:    o_word = enc_r(i_rs, i_rt, i_rd, C_FN_SUBU);
            OP_JR:      o_word = enc_r(i_rs, 5'd0, 5'd0, C_FN_JR);
            OP_SYSCALL: o_word = C_SYSCALL_WORD;
            OP_BEQ:     o_word = enc_i(C_OPC_BEQ,   i_rs, i_rt, w_imm16);
            OP_BNE:     o_word = enc_i(C_OPC_BNE,   i_rs, i_rt, w_imm16);
            OP_J:       o_word = enc_j(C_OPC_J,   i_target);
            OP_JAL:     o_word = enc_j(C_OPC_JAL, i_target);
            OP_ADDIU:   o_word = enc_i(C_OPC_ADDIU, i_rs, i_rt, w_imm16);
            OP_SLTI:    o_word = enc_i(C_OPC_SLTI,  i_rs, i_rt, w_imm16);
            OP_ORI:     o_word = enc_i(C_OPC_ORI,   i_rs, i_rt, w_imm16);
            OP_XORI:    o_word = enc_i(C_OPC_XORI,  i_rs, i_rt, w_imm16);
            OP_LUI:     o_word = enc_i(C_OPC_LUI,   5'd0, i_rt, w_imm16);
            OP_LW:      o_word = enc_i(C_OPC_LW,    i_rs, i_rt, w_imm16);
            OP_SW:      o_word = enc_i(C_OPC_SW,    i_rs, i_rt, w_imm16);
            OP_MOVE:    o_word = enc_r(i_rs, 5'd0, i_rd, C_FN_ADDU);
            OP_NOP:     o_word = C_NOP_WORD;
            OP_B:       o_word = enc_i(C_OPC_BEQ, 5'd0, 5'd0, w_imm16);
            OP_LI: begin
                // Phase 1 is only ever consumed for the LUI+ORI split.
                if (i_phase) begin
                    o_word = enc_i(C_OPC_ORI, i_rt, i_rt, w_imm16);
                end else if (LI_COMPACT && w_li_fits_ori) begin
                    o_word = enc_i(C_OPC_ORI, 5'd0, i_rt, w_imm16);
                end else if (LI_COMPACT && w_li_fits_addiu) begin
                    o_word = enc_i(C_OPC_ADDIU, 5'd0, i_rt, w_imm16);
                end else begin
                    o_word = enc_i(C_OPC_LUI, 5'd0, i_rt, i_imm[31:16]);
                end
                o_two_word = !i_phase && !w_li_single;
            end
            default:    o_invalid = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/instr_encoder_stream.sv
`default_nettype none
// ============================================================================
// Module : instr_encoder_stream
// Brief  : Assembles symbolic requests into MIPS words and streams them with addresses.
// Rev    : 1.0  initial release
// ============================================================================
module instr_encoder_stream
    import instr_encoder_stream_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_3000,
    parameter bit          LI_COMPACT = 1'b1
) (
    input  wire                     clk,
    input  wire                     rst_n,
    instr_encoder_stream_if.slave   bus,
    output logic                    err,
    output logic [15:0]             word_count
);

    enc_state_t  r_state;
    enc_state_t  w_state_next;

    logic [31:0] r_out_word;
    logic [31:0] r_out_addr;
    logic        r_out_valid;
    logic        r_out_last;
    logic [31:0] r_pending;
    logic        r_pending_last;
    logic        r_err;
    logic [15:0] r_word_count;

    logic [31:0] w_first_word;
    logic        w_first_two;
    logic        w_first_invalid;
    logic [31:0] w_second_word;
    logic        w_second_two;
    logic        w_second_invalid;

    logic        w_in_ready;
    logic        w_accept;
    logic        w_out_fire;
    logic        w_load_first;
    logic        w_load_second;
    logic        w_err_set;

    instr_word_pack #(.LI_COMPACT(LI_COMPACT)) u_pack_first (
        .i_op       (bus.in_op),
        .i_rs       (bus.in_rs),
        .i_rt       (bus.in_rt),
        .i_rd       (bus.in_rd),
        .i_imm      (bus.in_imm),
        .i_target   (bus.in_target),
        .i_phase    (1'b0),
        .o_word     (w_first_word),
        .o_two_word (w_first_two),
        .o_invalid  (w_first_invalid)
    );

    // The second word must be captured at accept time; the request fields are gone afterwards.
    instr_word_pack #(.LI_COMPACT(LI_COMPACT)) u_pack_second (
        .i_op       (bus.in_op),
        .i_rs       (bus.in_rs),
        .i_rt       (bus.in_rt),
        .i_rd       (bus.in_rd),
        .i_imm      (bus.in_imm),
        .i_target   (bus.in_target),
        .i_phase    (1'b1),
        .o_word     (w_second_word),
        .o_two_word (w_second_two),
        .o_invalid  (w_second_invalid)
    );

    assign w_in_ready = (r_state == S_IDLE) && (!r_out_valid || bus.out_ready);
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_out_fire = r_out_valid && bus.out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_load_first  = 1'b0;
        w_load_second = 1'b0;
        w_err_set     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_first_invalid) begin
                        w_err_set = 1'b1;
                    end else begin
                        w_load_first = 1'b1;
                        if (w_first_two) begin
                            w_state_next = S_SECOND;
                        end
                    end
                end
            end
            S_SECOND: begin
                if (w_out_fire) begin
                    w_load_second = 1'b1;
                    w_state_next  = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_word     <= 32'h0000_0000;
            r_out_addr     <= BASE_ADDR;
            r_out_valid    <= 1'b0;
            r_out_last     <= 1'b0;
            r_pending      <= 32'h0000_0000;
            r_pending_last <= 1'b0;
            r_err          <= 1'b0;
            r_word_count   <= 16'h0000;
        end else begin
            r_err <= w_err_set;
            // out_addr always names the slot of the word currently (or next) on the output.
            if (w_out_fire) begin
                r_out_addr   <= r_out_addr + 32'd4;
                r_word_count <= r_word_count + 16'd1;
            end
            if (w_load_first) begin
                r_out_word  <= w_first_word;
                r_out_last  <= !w_first_two;
                r_out_valid <= 1'b1;
                if (w_first_two && !w_second_invalid) begin
                    r_pending      <= w_second_word;
                    r_pending_last <= !w_second_two;
                end
            end else if (w_load_second) begin
                r_out_word  <= r_pending;
                r_out_last  <= r_pending_last;
                r_out_valid <= 1'b1;
            end else if (w_out_fire) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_word  = r_out_word;
    assign bus.out_addr  = r_out_addr;
    assign bus.out_last  = r_out_last;
    assign err           = r_err;
    assign word_count    = r_word_count;

endmodule
`default_nettype wire

// File: tb/tb_instr_encoder_stream.sv
`default_nettype none
// ============================================================================
// Module : tb_instr_encoder_stream
// Brief  : Directed and random checks of the encoder against a word-level reference model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_instr_encoder_stream;
    import instr_encoder_stream_pkg::*;

    localparam logic [31:0] BASE = 32'h0000_3000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        err, err_nc;
    logic [15:0] word_count, word_count_nc;

    always #5 clk = ~clk;

    instr_encoder_stream_if bus();
    instr_encoder_stream_if bus_nc();

    instr_encoder_stream #(.BASE_ADDR(BASE), .LI_COMPACT(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .err(err), .word_count(word_count));

    instr_encoder_stream #(.BASE_ADDR(BASE), .LI_COMPACT(1'b0)) dut_nc (
        .clk(clk), .rst_n(rst_n), .bus(bus_nc), .err(err_nc), .word_count(word_count_nc));

    typedef struct {
        logic [31:0] word;
        logic [31:0] addr;
        logic        last;
    } exp_t;

    int          total = 0;
    int          bad   = 0;
    exp_t        q[$];
    exp_t        log_q[$];
    logic [31:0] m_addr = BASE;
    logic [15:0] m_count = 16'h0;
    bit          m_err_exp = 1'b0;
    bit          m_exp_ready;
    int          m_n;
    logic [31:0] m_w0, m_w1;

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] f_r(input logic [31:0] rs, rt, rd, fn);
        return (rs << 21) | (rt << 16) | (rd << 11) | fn;
    endfunction

    function automatic logic [31:0] f_i(input logic [31:0] opc, rs, rt, imm16);
        return (opc << 26) | (rs << 21) | (rt << 16) | (imm16 & 32'hFFFF);
    endfunction

    // Number of words a request expands to (0 = unknown op), and the words themselves.
    function automatic int ref_expand(input logic [4:0] op, rs, rt, rd, input logic [31:0] imm,
                                      input logic [25:0] tgt, input bit compact,
                                      output logic [31:0] w0, output logic [31:0] w1);
        int n;
        n  = 1;
        w0 = 32'h0;
        w1 = 32'h0;
        case (asm_op_t'(op))
            OP_ADDU:    w0 = f_r(rs, rt, rd, 32'h21);
            OP_SUBU:    w0 = f_r(rs, rt, rd, 32'h23);
            OP_JR:      w0 = f_r(rs, 0, 0, 32'h08);
            OP_SYSCALL: w0 = 32'h0000000C;
            OP_BEQ:     w0 = f_i(32'h04, rs, rt, imm);
            OP_BNE:     w0 = f_i(32'h05, rs, rt, imm);
            OP_J:       w0 = (32'h02 << 26) | 32'(tgt);
            OP_JAL:     w0 = (32'h03 << 26) | 32'(tgt);
            OP_ADDIU:   w0 = f_i(32'h09, rs, rt, imm);
            OP_SLTI:    w0 = f_i(32'h0a, rs, rt, imm);
            OP_ORI:     w0 = f_i(32'h0d, rs, rt, imm);
            OP_XORI:    w0 = f_i(32'h0e, rs, rt, imm);
            OP_LUI:     w0 = f_i(32'h0f, 0, rt, imm);
            OP_LW:      w0 = f_i(32'h23, rs, rt, imm);
            OP_SW:      w0 = f_i(32'h2b, rs, rt, imm);
            OP_MOVE:    w0 = f_r(rs, 0, rd, 32'h21);
            OP_NOP:     w0 = 32'h00000021;
            OP_B:       w0 = f_i(32'h04, 0, 0, imm);
            OP_LI: begin
                if (compact && imm < 32'h0001_0000) begin
                    w0 = f_i(32'h0d, 0, rt, imm);
                end else if (compact && $signed(imm) < 0 && $signed(imm) >= -32768) begin
                    w0 = f_i(32'h09, 0, rt, imm);
                end else begin
                    n  = 2;
                    w0 = f_i(32'h0f, 0, rt, imm >> 16);
                    w1 = f_i(32'h0d, rt, rt, imm);
                end
            end
            default:    n = 0;
        endcase
        return n;
    endfunction

    // Scoreboard for the compact encoder: q[0] is the word that must be on the output.
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            m_addr    = BASE;
            m_count   = 16'h0;
            m_err_exp = 1'b0;
        end else begin
            m_exp_ready = (q.size() == 0) || (q.size() == 1 && bus.out_ready);
            chk1("out_valid", bus.out_valid, q.size() != 0);
            if (q.size() != 0) begin
                chk32("out_word", bus.out_word, q[0].word);
                chk32("out_addr", bus.out_addr, q[0].addr);
                chk1("out_last", bus.out_last, q[0].last);
            end
            chk1("in_ready", bus.in_ready, m_exp_ready);
            chk1("err", err, m_err_exp);
            chk32("word_count", 32'(word_count), 32'(m_count));
            m_err_exp = 1'b0;
            if (bus.out_valid && bus.out_ready) begin
                log_q.push_back('{bus.out_word, bus.out_addr, bus.out_last});
            end
            if (q.size() != 0 && bus.out_ready) begin
                void'(q.pop_front());
                m_count = m_count + 16'd1;
            end
            if (bus.in_valid && m_exp_ready) begin
                m_n = ref_expand(bus.in_op, bus.in_rs, bus.in_rt, bus.in_rd, bus.in_imm,
                                 bus.in_target, 1'b1, m_w0, m_w1);
                if (m_n == 0) begin
                    m_err_exp = 1'b1;
                end else begin
                    q.push_back('{m_w0, m_addr, m_n == 1});
                    m_addr = m_addr + 32'd4;
                    if (m_n == 2) begin
                        q.push_back('{m_w1, m_addr, 1'b1});
                        m_addr = m_addr + 32'd4;
                    end
                end
            end
        end
    end

    // Called and returning at posedge+1.
    task automatic send(input logic [4:0] op, rs, rt, rd, input logic [31:0] imm,
                        input logic [25:0] tgt, input bit rnd, output int waits);
        bus.in_op     = op;
        bus.in_rs     = rs;
        bus.in_rt     = rt;
        bus.in_rd     = rd;
        bus.in_imm    = imm;
        bus.in_target = tgt;
        bus.in_valid  = 1'b1;
        waits = 0;
        if (rnd) bus.out_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        while (!bus.in_ready && waits <= 50) begin
            @(posedge clk);
            #1;
            if (rnd) bus.out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            waits++;
        end
        chk1("accept", bus.in_ready, 1'b1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        bus.out_ready = 1'b1;
        while ((q.size() != 0 || bus.out_valid) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk1("drain", bus.out_valid, 1'b0);
    endtask

    task automatic do_reset();
        bus.in_valid    = 1'b0;
        bus_nc.in_valid = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int w;
        int mark;
        int cnt;
        logic [31:0] nc_word[2];
        logic [31:0] nc_addr[2];
        logic        nc_last[2];
        logic [4:0]  rop;
        logic [31:0] rimm;
        int          sel;

        bus.in_valid = 1'b0; bus.in_op = 5'd0; bus.in_rs = 5'd0; bus.in_rt = 5'd0;
        bus.in_rd = 5'd0; bus.in_imm = 32'h0; bus.in_target = 26'h0; bus.out_ready = 1'b1;
        bus_nc.in_valid = 1'b0; bus_nc.in_op = 5'd0; bus_nc.in_rs = 5'd0; bus_nc.in_rt = 5'd0;
        bus_nc.in_rd = 5'd0; bus_nc.in_imm = 32'h0; bus_nc.in_target = 26'h0; bus_nc.out_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk1("rst_out_valid", bus.out_valid, 1'b0);
        chk32("rst_out_word", bus.out_word, 32'h0);
        chk32("rst_out_addr", bus.out_addr, BASE);
        chk1("rst_out_last", bus.out_last, 1'b0);
        chk1("rst_err", err, 1'b0);
        chk32("rst_word_count", 32'(word_count), 32'h0);
        @(posedge clk);
        #1;

        // ADDU rd=3, rs=1, rt=2
        mark = log_q.size();
        send(5'(OP_ADDU), 5'd1, 5'd2, 5'd3, 32'h0, 26'h0, 1'b0, w);
        drain();
        chk32("addu_cnt", 32'(log_q.size()), 32'(mark + 1));
        chk32("addu_word", log_q[mark].word, 32'h00221821);
        chk32("addu_addr", log_q[mark].addr, 32'h00003000);
        chk1("addu_last", log_q[mark].last, 1'b1);

        // ORI then SYSCALL back-to-back
        do_reset();
        mark = log_q.size();
        send(5'(OP_ORI), 5'd0, 5'd8, 5'd0, 32'h1234, 26'h0, 1'b0, w);
        send(5'(OP_SYSCALL), 5'd0, 5'd0, 5'd0, 32'h0, 26'h0, 1'b0, w);
        chk32("b2b_waits", 32'(w), 32'd0);
        drain();
        chk32("b2b_w0", log_q[mark].word, 32'h34081234);
        chk32("b2b_a0", log_q[mark].addr, 32'h00003000);
        chk32("b2b_w1", log_q[mark + 1].word, 32'h0000000C);
        chk32("b2b_a1", log_q[mark + 1].addr, 32'h00003004);

        // LI split with a 3-cycle sink stall
        do_reset();
        mark = log_q.size();
        bus.out_ready = 1'b0;
        send(5'(OP_LI), 5'd0, 5'd8, 5'd0, 32'h12345678, 26'h0, 1'b0, w);
        repeat (3) begin
            @(negedge clk);
            chk32("stall_word", bus.out_word, 32'h3C081234);
            chk1("stall_last", bus.out_last, 1'b0);
            chk1("stall_in_ready", bus.in_ready, 1'b0);
        end
        @(posedge clk);
        #1;
        drain();
        chk32("li_w0", log_q[mark].word, 32'h3C081234);
        chk1("li_l0", log_q[mark].last, 1'b0);
        chk32("li_w1", log_q[mark + 1].word, 32'h35085678);
        chk32("li_a1", log_q[mark + 1].addr, 32'h00003004);
        chk1("li_l1", log_q[mark + 1].last, 1'b1);

        // LI sign-extendable immediate: one word compact, two words otherwise
        do_reset();
        mark = log_q.size();
        send(5'(OP_LI), 5'd0, 5'd8, 5'd0, 32'hFFFF8000, 26'h0, 1'b0, w);
        bus_nc.in_op = 5'(OP_LI); bus_nc.in_rt = 5'd8; bus_nc.in_imm = 32'hFFFF8000;
        bus_nc.in_valid = 1'b1;
        cnt = 0;
        @(negedge clk);
        while (!bus_nc.in_ready && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        @(posedge clk);
        #1;
        bus_nc.in_valid = 1'b0;
        cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus_nc.out_valid && bus_nc.out_ready && cnt < 2) begin
                nc_word[cnt] = bus_nc.out_word;
                nc_addr[cnt] = bus_nc.out_addr;
                nc_last[cnt] = bus_nc.out_last;
                cnt++;
            end
        end
        drain();
        chk32("li_neg_cnt", 32'(log_q.size()), 32'(mark + 1));
        chk32("li_neg_word", log_q[mark].word, 32'h24088000);
        chk32("nc_cnt", 32'(cnt), 32'd2);
        chk32("nc_w0", nc_word[0], 32'h3C08FFFF);
        chk32("nc_a0", nc_addr[0], 32'h00003000);
        chk1("nc_l0", nc_last[0], 1'b0);
        chk32("nc_w1", nc_word[1], 32'h35088000);
        chk32("nc_a1", nc_addr[1], 32'h00003004);
        chk1("nc_l1", nc_last[1], 1'b1);
        chk32("nc_word_count", 32'(word_count_nc), 32'd2);
        chk1("nc_err", err_nc, 1'b0);

        // JAL
        mark = log_q.size();
        send(5'(OP_JAL), 5'd0, 5'd0, 5'd0, 32'h0, 26'h0000C03, 1'b0, w);
        drain();
        chk32("jal_word", log_q[mark].word, 32'h0C000C03);
        chk32("jal_addr", log_q[mark].addr, 32'h00003004);

        // Unknown op
        do_reset();
        mark = log_q.size();
        send(5'd25, 5'd1, 5'd2, 5'd3, 32'h0, 26'h0, 1'b0, w);
        @(negedge clk);
        chk1("inv_err", err, 1'b1);
        chk1("inv_out_valid", bus.out_valid, 1'b0);
        @(negedge clk);
        chk1("inv_err_clear", err, 1'b0);
        @(posedge clk);
        #1;
        send(5'(OP_ADDU), 5'd1, 5'd2, 5'd3, 32'h0, 26'h0, 1'b0, w);
        drain();
        chk32("inv_next_addr", log_q[mark].addr, 32'h00003000);
        chk32("inv_word_count", 32'(word_count), 32'd1);

        // Reset while the second LI word is pending
        do_reset();
        bus.out_ready = 1'b0;
        send(5'(OP_LI), 5'd0, 5'd8, 5'd0, 32'h12345678, 26'h0, 1'b0, w);
        @(negedge clk);
        chk1("second_in_ready", bus.in_ready, 1'b0);
        @(posedge clk);
        #1;
        do_reset();
        @(negedge clk);
        chk1("rst2_out_valid", bus.out_valid, 1'b0);
        chk32("rst2_word_count", 32'(word_count), 32'd0);
        chk32("rst2_addr", bus.out_addr, BASE);
        @(posedge clk);
        #1;
        mark = log_q.size();
        bus.out_ready = 1'b1;
        send(5'(OP_NOP), 5'd0, 5'd0, 5'd0, 32'h0, 26'h0, 1'b0, w);
        drain();
        chk32("rst2_cnt", 32'(log_q.size()), 32'(mark + 1));
        chk32("rst2_word", log_q[mark].word, 32'h00000021);
        chk32("rst2_word_addr", log_q[mark].addr, BASE);

        // Random requests with a randomly stalling sink
        do_reset();
        for (int i = 0; i < 300; i++) begin
            sel = int'($urandom_range(0, 21));
            if (sel > 18) rop = 5'(19 + $urandom_range(0, 12));
            else          rop = 5'(sel);
            case ($urandom_range(0, 2))
                0:       rimm = {16'h0000, 16'($urandom)};
                1:       rimm = {17'h1FFFF, 15'($urandom)};
                default: rimm = $urandom;
            endcase
            send(rop, 5'($urandom), 5'($urandom), 5'($urandom), rimm, 26'($urandom), 1'b1, w);
        end
        drain();
        @(negedge clk);
        chk32("rand_final_count", 32'(word_count), 32'(m_count));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
